// File: rtl/box2x_down.sv
// box2x_down: 2:1 box-filter downscaler, 2x2 average per output pixel,
// presented through a double-buffered half-line RAM on a separate ce_out.
module box2x_down #(
   parameter int  LENGTH     = 1024,
   parameter int  HALF_DEPTH = 0,
   localparam int DWIDTH     = (HALF_DEPTH != 0) ? 11 : 23
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ce_in,
   input  logic [DWIDTH:0] inputpixel,
   input  logic            reset_line,
   input  logic            reset_frame,
   input  logic            ce_out,
   input  logic            hblank,
   output logic [DWIDTH:0] outpixel
);

   localparam int CW = (HALF_DEPTH != 0) ? 4 : 8;
   localparam int SW = 3 * (CW + 1);
   localparam int AW = $clog2(LENGTH);
   localparam int HW = AW - 1;

   localparam logic [AW-1:0] IX_MAX = AW'(LENGTH - 1);
   localparam logic [HW-1:0] RX_MAX = HW'(LENGTH / 2 - 1);

   logic [SW-1:0]     sram [LENGTH/2];
   logic [DWIDTH:0]   oram [LENGTH];

   logic              rl_q, rl_d;
   logic              rf_q, rf_d;
   logic              act_q, act_d;
   logic              done_q, done_d;
   logic              lp_q, lp_d;
   logic              wbank_q, wbank_d;
   logic              rbank_q, rbank_d;
   logic [AW-1:0]     ix_q, ix_d;
   logic [DWIDTH:0]   hold_q, hold_d;
   logic              owr_q, owr_d;
   logic [AW-1:0]     owa_q, owa_d;
   logic [DWIDTH:0]   owd_q, owd_d;
   logic [HW-1:0]     rx_q;
   logic [DWIDTH:0]   outpixel_q;
   logic [SW-1:0]     sum_q;
   logic [DWIDTH:0]   rdat_q;

   logic              line_start;
   logic              frame_start;
   logic              pix_v;
   logic              odd_px;
   logic [HW-1:0]     haddr;
   logic [SW-1:0]     psum;
   logic [DWIDTH:0]   avg;
   logic [CW+1:0]     tot;

   assign line_start  = ce_in & rl_q & ~reset_line;
   assign frame_start = rf_q & ~reset_frame;
   // The line-start strobe itself carries no pixel; only act_q lines count.
   assign pix_v  = ce_in & ~reset_line & ~rl_q & act_q & ~done_q;
   assign odd_px = ix_q[0];
   assign haddr  = ix_q[AW-1:1];

   always_comb begin
      psum = '0;
      avg  = '0;
      tot  = '0;
      for (int c = 0; c < 3; c++) begin
         psum[c*(CW+1) +: CW+1] = {1'b0, hold_q[c*CW +: CW]}
                                + {1'b0, inputpixel[c*CW +: CW]};
         tot = {1'b0, sum_q[c*(CW+1) +: CW+1]}
             + {1'b0, psum[c*(CW+1) +: CW+1]} + (CW+2)'(2);
         avg[c*CW +: CW] = tot[CW+1:2];
      end
   end

   always_comb begin
      rl_d    = ce_in ? reset_line : rl_q;
      rf_d    = rf_q;
      act_d   = act_q;
      done_d  = done_q;
      lp_d    = lp_q;
      wbank_d = wbank_q;
      rbank_d = rbank_q;
      ix_d    = ix_q;
      hold_d  = hold_q;
      if (line_start) begin
         ix_d   = '0;
         done_d = 1'b0;
         act_d  = 1'b1;
         rf_d   = reset_frame;
         lp_d   = (~act_q | frame_start) ? 1'b0 : ~lp_q;
         // A frame restart abandons the pending pair of lines.
         if (act_q & lp_q & ~frame_start) begin
            rbank_d = wbank_q;
            wbank_d = ~wbank_q;
         end
      end else if (pix_v) begin
         if (ix_q == IX_MAX) done_d = 1'b1;
         else ix_d = ix_q + 1'b1;
         if (!odd_px) hold_d = inputpixel;
      end
   end

   always_comb begin
      owr_d = pix_v & odd_px & lp_q;
      owa_d = {wbank_q, haddr};
      owd_d = avg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rl_q    <= 1'b0;
         rf_q    <= 1'b0;
         act_q   <= 1'b0;
         done_q  <= 1'b0;
         lp_q    <= 1'b0;
         wbank_q <= 1'b1;
         rbank_q <= 1'b0;
         ix_q    <= '0;
         hold_q  <= '0;
         owr_q   <= 1'b0;
         owa_q   <= '0;
         owd_q   <= '0;
      end else begin
         rl_q    <= rl_d;
         rf_q    <= rf_d;
         act_q   <= act_d;
         done_q  <= done_d;
         lp_q    <= lp_d;
         wbank_q <= wbank_d;
         rbank_q <= rbank_d;
         ix_q    <= ix_d;
         hold_q  <= hold_d;
         owr_q   <= owr_d;
         owa_q   <= owa_d;
         owd_q   <= owd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (pix_v & odd_px & ~lp_q) sram[haddr] <= psum;
      if (pix_v & ~odd_px & lp_q) sum_q <= sram[haddr];
      if (owr_q) oram[owa_q] <= owd_q;
      rdat_q <= oram[{rbank_q, rx_q}];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_q       <= '0;
         outpixel_q <= '0;
      end else if (ce_out) begin
         if (hblank) begin
            rx_q       <= '0;
            outpixel_q <= '0;
         end else begin
            outpixel_q <= rdat_q;
            if (rx_q != RX_MAX) rx_q <= rx_q + 1'b1;
         end
      end
   end

   assign outpixel = outpixel_q;

endmodule

// File: tb/tb_box2x_down.sv
// Scoreboard bench for box2x_down: a 24-bit and a 12-bit instance share
// one stimulus stream; expected pixels come from a 2x2 average model.
module tb_box2x_down;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce_in = 1'b0;
   logic [23:0] px24 = '0;
   logic        reset_line = 1'b1;
   logic        reset_frame = 1'b0;
   logic        ce_out = 1'b0;
   logic        hblank = 1'b1;
   logic [23:0] out24;
   logic [11:0] out12;

   int checks = 0;
   int errors = 0;

   logic [23:0] ev [10];
   logic [23:0] od [10];
   logic [23:0] cur [10];
   logic [23:0] e24 [4];
   logic [23:0] e12 [4];
   logic [23:0] q24 [$];
   logic [23:0] q12 [$];

   always #5 clk = ~clk;

   box2x_down #(.LENGTH(8), .HALF_DEPTH(0)) u_dut (
      .clk(clk), .rst(rst), .ce_in(ce_in), .inputpixel(px24),
      .reset_line(reset_line), .reset_frame(reset_frame),
      .ce_out(ce_out), .hblank(hblank), .outpixel(out24)
   );

   box2x_down #(.LENGTH(8), .HALF_DEPTH(1)) u_half (
      .clk(clk), .rst(rst), .ce_in(ce_in), .inputpixel(px24[11:0]),
      .reset_line(reset_line), .reset_frame(reset_frame),
      .ce_out(ce_out), .hblank(hblank), .outpixel(out12)
   );

   task automatic chk(input string tag, input logic [23:0] got,
                      input logic [23:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] avg4(input logic [23:0] a, b, c, d,
                                        input int cw);
      logic [23:0] r;
      int m, s;
      r = '0;
      m = (1 << cw) - 1;
      for (int ch = 0; ch < 3; ch++) begin
         s = int'((a >> (ch*cw)) & m) + int'((b >> (ch*cw)) & m)
           + int'((c >> (ch*cw)) & m) + int'((d >> (ch*cw)) & m) + 2;
         r = r | (24'((s >> 2) & m) << (ch*cw));
      end
      return r;
   endfunction

   task automatic pulse_in(input logic [23:0] p);
      @(negedge clk);
      px24  = p;
      ce_in = 1'b1;
      @(negedge clk);
      ce_in = 1'b0;
      @(negedge clk);
   endtask

   task automatic begin_line();
      reset_line = 1'b0;
      pulse_in(24'h0);
   endtask

   task automatic end_line();
      reset_line = 1'b1;
      pulse_in(24'h0);
      pulse_in(24'h0);
   endtask

   task automatic send_px(input int n);
      for (int i = 0; i < n; i++) pulse_in(cur[i]);
   endtask

   task automatic do_block(input int n);
      cur = ev;
      send_px(n);
      end_line();
      begin_line();
      cur = od;
      send_px(n);
      end_line();
      begin_line();
      for (int j = 0; j < 4; j++) begin
         e24[j] = avg4(ev[2*j], ev[2*j+1], od[2*j], od[2*j+1], 8);
         e12[j] = avg4(ev[2*j] & 24'hFFF, ev[2*j+1] & 24'hFFF,
                       od[2*j] & 24'hFFF, od[2*j+1] & 24'hFFF, 4);
      end
   endtask

   task automatic rd_px(input logic hb, input logic [23:0] x24,
                        input logic [23:0] x12, input string tag);
      logic [23:0] w24, w12;
      q24.push_back(x24);
      q12.push_back(x12);
      @(negedge clk);
      ce_out = 1'b1;
      hblank = hb;
      @(negedge clk);
      ce_out = 1'b0;
      @(negedge clk);
      w24 = q24.pop_front();
      w12 = q12.pop_front();
      chk({tag, "_24"}, out24, w24);
      chk({tag, "_12"}, {12'h0, out12}, w12);
   endtask

   task automatic read_line(input int nr, input string tag);
      int k;
      rd_px(1'b1, 24'h0, 24'h0, {tag, "_hb"});
      for (int j = 0; j < nr; j++) begin
         k = (j > 3) ? 3 : j;
         rd_px(1'b0, e24[k], e12[k], $sformatf("%s[%0d]", tag, j));
      end
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 10; i++) begin
         ev[i] = 24'($urandom);
         od[i] = 24'($urandom);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_out24", out24, 24'h0);
      chk("rst_out12", {12'h0, out12}, 24'h0);
      rst = 1'b0;
      pulse_in(24'h0);
      begin_line();

      for (int i = 0; i < 10; i++) begin
         ev[i] = 24'h408020;
         od[i] = 24'h408020;
      end
      do_block(8);
      read_line(5, "const");

      fill_rand();
      ev[0] = 24'h000001; ev[1] = 24'h000002;
      ev[2] = 24'h0000FF; ev[3] = 24'h0000FF;
      od[0] = 24'h000002; od[1] = 24'h000002;
      od[2] = 24'h0000FF; od[3] = 24'h0000FF;
      do_block(8);
      read_line(4, "round");

      fill_rand();
      ev[0] = 24'h00000F; ev[1] = 24'h00000F;
      od[0] = 24'h00000F; od[1] = 24'h00000E;
      do_block(8);
      read_line(4, "half");

      fill_rand();
      do_block(10);
      read_line(4, "sat");
      repeat (3) @(negedge clk);
      chk("hold_24", out24, e24[3]);
      chk("hold_12", {12'h0, out12}, e12[3]);
      rd_px(1'b1, 24'h0, 24'h0, "hblank");

      for (int i = 0; i < 10; i++) cur[i] = 24'($urandom);
      send_px(8);
      end_line();
      reset_frame = 1'b1;
      begin_line();
      end_line();
      reset_frame = 1'b0;
      begin_line();
      read_line(4, "frm_a");
      for (int i = 0; i < 10; i++) begin
         ev[i] = 24'h123456;
         od[i] = 24'h123456;
      end
      cur = ev;
      send_px(8);
      end_line();
      begin_line();
      read_line(4, "frm_b");
      cur = od;
      send_px(8);
      end_line();
      begin_line();
      for (int j = 0; j < 4; j++) begin
         e24[j] = 24'h123456;
         e12[j] = 24'h000456;
      end
      read_line(4, "frm_c");

      for (int i = 0; i < 10; i++) cur[i] = 24'($urandom);
      send_px(5);
      #2 rst = 1'b1;
      #1;
      chk("arst_24", out24, 24'h0);
      chk("arst_12", {12'h0, out12}, 24'h0);
      @(negedge clk);
      rst = 1'b0;
      send_px(3);
      end_line();
      begin_line();
      fill_rand();
      do_block(8);
      read_line(4, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
